// File: rtl/regfile_writeback_unit_pkg.sv
// Shared widths, the writeback entry type and the hard-wired zero register index
// used by the register-file writeback unit and its load-path FIFO.
package regfile_writeback_unit_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // 'dest' carries the destination register index; 'reg' is a reserved word
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Producer, register-file write port and forwarding signals of the writeback unit.
interface regfile_writeback_unit_if
    import regfile_writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic              alu_valid;
    logic [REG_AW-1:0] alu_reg;
    logic [XLEN-1:0]   alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_reg;
    logic [XLEN-1:0]   ld_data;
    logic              RegWrite;
    logic [REG_AW-1:0] WriteReg;
    logic [XLEN-1:0]   WriteData;
    logic [REG_AW-1:0] q_reg;
    logic              q_hit;
    logic [XLEN-1:0]   q_data;
    logic [AW:0]       pending;

    modport master (
        output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data, q_reg,
        input  ld_ready, RegWrite, WriteReg, WriteData, q_hit, q_data, pending
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data, q_reg,
        output ld_ready, RegWrite, WriteReg, WriteData, q_hit, q_data, pending
    );

endinterface

// File: rtl/regfile_writeback_unit_wb_fifo.sv
// Load-path FIFO: per-entry kill by destination register and a combinational
// youngest-valid-match lookup for forwarding.
module wb_fifo
    import regfile_writeback_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [REG_AW-1:0] i_push_reg,
    input  logic [XLEN-1:0]   i_push_data,
    input  logic              i_pop,
    input  logic              i_kill_en,
    input  logic [REG_AW-1:0] i_kill_reg,
    input  logic [REG_AW-1:0] i_q_reg,
    output logic              o_q_hit,
    output logic [XLEN-1:0]   o_q_data,
    output wb_entry_t         o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_count
);

    wb_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            // Kill and push never target the same live slot: the tail slot is free.
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && r_mem[i].dest == i_kill_reg) r_mem[i].valid <= 1'b0;
            end
            if (i_push) begin
                r_mem[r_wr_ptr] <= '{valid: 1'b1, dest: i_push_reg, data: i_push_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk head to tail so the last match found is the youngest.
    always_comb begin
        o_q_hit  = 1'b0;
        o_q_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < r_count && r_mem[r_rd_ptr + AW'(i)].valid &&
                r_mem[r_rd_ptr + AW'(i)].dest == i_q_reg) begin
                o_q_hit  = 1'b1;
                o_q_data = r_mem[r_rd_ptr + AW'(i)].data;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/regfile_writeback_unit.sv
// Owns the register-file write port: ALU results take priority, queued load results
// drain when the ALU is idle, and pending values are forwarded on request.
module regfile_writeback_unit
    import regfile_writeback_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_writeback_unit_if.slave  bus
);

    logic              r_reg_write;
    logic [REG_AW-1:0] r_write_reg;
    logic [XLEN-1:0]   r_write_data;

    logic              w_alu_acc;
    logic              w_ld_fire;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_fifo_hit;
    logic [XLEN-1:0]   w_fifo_data;
    logic              w_stage_hit;
    logic              w_q_nz;
    wb_entry_t         w_head;
    logic [AW:0]       w_count;

    assign w_alu_acc = bus.alu_valid && (bus.alu_reg != REG_ZERO);
    assign w_ld_fire = bus.ld_valid && !w_full;
    // A load to $0, or one overtaken by a same-cycle ALU write, completes but is dropped.
    assign w_push    = w_ld_fire && (bus.ld_reg != REG_ZERO) &&
                       !(w_alu_acc && bus.ld_reg == bus.alu_reg);
    assign w_pop     = !w_alu_acc && !w_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_reg  (bus.ld_reg),
        .i_push_data (bus.ld_data),
        .i_pop       (w_pop),
        .i_kill_en   (w_alu_acc),
        .i_kill_reg  (bus.alu_reg),
        .i_q_reg     (bus.q_reg),
        .o_q_hit     (w_fifo_hit),
        .o_q_data    (w_fifo_data),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (w_alu_acc) begin
            r_reg_write  <= 1'b1;
            r_write_reg  <= bus.alu_reg;
            r_write_data <= bus.alu_data;
        end else if (w_pop) begin
            r_reg_write  <= w_head.valid;
            r_write_reg  <= w_head.dest;
            r_write_data <= w_head.data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    // Queued entries are always younger than the output stage, so the FIFO wins.
    assign w_q_nz      = (bus.q_reg != REG_ZERO);
    assign w_stage_hit = r_reg_write && (r_write_reg == bus.q_reg);

    assign bus.q_hit   = w_q_nz && (w_fifo_hit || w_stage_hit);
    assign bus.q_data  = !w_q_nz    ? '0 :
                         w_fifo_hit  ? w_fifo_data :
                         w_stage_hit ? r_write_data : '0;

    assign bus.ld_ready  = !w_full;
    assign bus.pending   = w_count;
    assign bus.RegWrite  = r_reg_write;
    assign bus.WriteReg  = r_write_reg;
    assign bus.WriteData = r_write_data;

endmodule
